// File: rtl/pattern_pkg.sv
// Shared constants, types and FSM state encoding for the bit pattern sequencer.
package pattern_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [AW-1:0]    addr_t;
  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT
  } seq_state_e;

endpackage

// File: rtl/bit_pattern_sequencer_if.sv
// Host-side bundle: playback control, write port and serial output of the sequencer.
interface bit_pattern_sequencer_if #(
  parameter  int WIDTH = pattern_pkg::WIDTH,
  parameter  int DEPTH = pattern_pkg::DEPTH,
  localparam int AW    = $clog2(DEPTH)
);

  logic             start;
  logic             stop;
  logic             loop;
  logic [AW-1:0]    len;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ack;
  logic             busy;
  logic [AW-1:0]    addr;
  logic             out;
  logic             out_valid;
  logic             done;

  modport master (
    output start, stop, loop, len, wr_en, wr_addr, wr_data,
    input  wr_ack, busy, addr, out, out_valid, done
  );

  modport slave (
    input  start, stop, loop, len, wr_en, wr_addr, wr_data,
    output wr_ack, busy, addr, out, out_valid, done
  );

endinterface

// File: rtl/pattern_mem.sv
// Pattern register file: one synchronous write port, one combinational read port,
// every word cleared by reset.
module pattern_mem #(
  parameter  int WIDTH = pattern_pkg::WIDTH,
  parameter  int DEPTH = pattern_pkg::DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array must be a flop bank (not RAM) because reset has to clear every word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/bit_pattern_sequencer.sv
// Playback FSM walking addresses 0..len and emitting the diagonal bit mem[i][i],
// sharing the single memory port between engine fetches and host writes.
module bit_pattern_sequencer
  import pattern_pkg::*;
#(
  parameter  int WIDTH = pattern_pkg::WIDTH,
  parameter  int DEPTH = pattern_pkg::DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  bit_pattern_sequencer_if.slave  bus
);

  seq_state_e       r_state;
  seq_state_e       w_next;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    r_len_q;
  logic             r_loop_q;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_rd_data;
  logic             r_out;
  logic             r_out_valid;
  logic             r_done;
  logic             w_wr_ack;
  logic             w_last;
  logic             w_launch;

  // The fetch owns the port in FETCH; a refused writer is served in the following EMIT.
  assign w_wr_ack = bus.wr_en && (r_state != FETCH);
  assign w_last   = (r_idx == r_len_q);
  assign w_launch = bus.start && !bus.stop;

  pattern_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (w_wr_ack),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (r_idx),
    .rdata (w_rd_data)
  );

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_launch) w_next = FETCH;
      FETCH:   w_next = bus.stop ? IDLE : EMIT;
      EMIT:    w_next = (bus.stop || (w_last && !r_loop_q)) ? IDLE : FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx       <= '0;
      r_len_q     <= '0;
      r_loop_q    <= 1'b0;
      r_word      <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_len_q  <= bus.len;
            r_loop_q <= bus.loop;
            r_idx    <= '0;
          end
        end
        FETCH: begin
          if (!bus.stop) r_word <= w_rd_data;
        end
        EMIT: begin
          // stop suppresses the emit and the index advance; out keeps its last value
          if (!bus.stop) begin
            r_out       <= r_word[r_idx];
            r_out_valid <= 1'b1;
            if (!w_last)       r_idx  <= r_idx + 1'b1;
            else if (r_loop_q) r_idx  <= '0;
            else               r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_ack    = w_wr_ack;
  assign bus.busy      = (r_state != IDLE);
  assign bus.addr      = r_idx;
  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = r_done;

endmodule
